// File: rtl/uart_rx.sv
// uart_rx: oversampled UART receiver (7/8 data bits); even parity check and perr_o added when UART_RX_PARITY_EN is defined
module uart_rx #(
  parameter int OVS = 16,
  parameter int SYNC_STAGES = 2
) (
  input  logic       clk_i,
  input  logic       rst_ni,
  input  logic       rx_i,
  input  logic       tick_i,
  input  logic       dlen_i,
  output logic [7:0] data_o,
  output logic       valid_o,
  output logic       ferr_o,
  output logic       busy_o
`ifdef UART_RX_PARITY_EN
  ,
  output logic       perr_o
`endif
);
  localparam int TW = $clog2(OVS);
  typedef enum logic [2:0] {
    IDLE, START, DATA, STOP, BREAK
`ifdef UART_RX_PARITY_EN
    , PARITY
`endif
  } state_t;
  state_t state, next;
  logic [SYNC_STAGES-1:0] sync;
  logic rxs;
  logic [TW-1:0] tcnt;
  logic [2:0] bcnt;
  logic [7:0] sh, frame;
  logic dlen_r, mid, full, last;
  logic start, counting, shift, done;
`ifdef UART_RX_PARITY_EN
  logic par;
`endif
  // synchroniser resets to the idle-high line level so reset release never looks like a start bit
  always_ff @(posedge clk_i or negedge rst_ni)
    if (!rst_ni) sync <= '1;
    else sync <= {sync[SYNC_STAGES-2:0], rx_i};
  assign rxs = sync[SYNC_STAGES-1];
  assign mid = tick_i && tcnt == TW'(OVS / 2 - 1);
  assign full = tick_i && tcnt == TW'(OVS - 1);
  assign last = bcnt == (dlen_r ? 3'd7 : 3'd6);
  assign frame = dlen_r ? sh : {1'b0, sh[7:1]};
  // state register
  always_ff @(posedge clk_i or negedge rst_ni)
    if (!rst_ni) state <= IDLE;
    else state <= next;
  // next-state logic; a false start is rejected at the middle of the start bit
  always_comb begin
    next = state;
    case (state)
      IDLE:   if (!rxs) next = START;
      START:  if (mid) next = rxs ? IDLE : DATA;
`ifdef UART_RX_PARITY_EN
      DATA:   if (full && last) next = PARITY;
      PARITY: if (full) next = STOP;
`else
      DATA:   if (full && last) next = STOP;
`endif
      STOP:   if (full) next = rxs ? IDLE : BREAK;
      BREAK:  if (rxs) next = IDLE;
      default: next = IDLE;
    endcase
  end
  // output/strobe decode from the current state
  always_comb begin
    start = state == IDLE && !rxs;
    counting = tick_i && state != IDLE && state != BREAK;
    shift = state == DATA && full;
    done = state == STOP && full;
    busy_o = state != IDLE;
  end
  // tick/bit counters and shift register; tcnt wraps OVS-1 -> 0 on its own since OVS is a power of two
  always_ff @(posedge clk_i or negedge rst_ni)
    if (!rst_ni) begin
      tcnt <= '0;
      bcnt <= '0;
      dlen_r <= 1'b0;
      sh <= '0;
`ifdef UART_RX_PARITY_EN
      par <= 1'b0;
`endif
    end else begin
      if (start) begin
        tcnt <= '0;
        dlen_r <= dlen_i;
      end else if (state == START && mid) begin
        tcnt <= '0;
        bcnt <= '0;
      end else if (counting) tcnt <= tcnt + TW'(1);
      if (shift) begin
        sh <= {rxs, sh[7:1]};
        bcnt <= bcnt + 3'd1;
      end
`ifdef UART_RX_PARITY_EN
      if (state == PARITY && full) par <= rxs;
`endif
    end
  // registered frame outputs: valid and flags pulse one clk after the stop-bit sample, data holds
  always_ff @(posedge clk_i or negedge rst_ni)
    if (!rst_ni) begin
      data_o <= '0;
      valid_o <= 1'b0;
      ferr_o <= 1'b0;
`ifdef UART_RX_PARITY_EN
      perr_o <= 1'b0;
`endif
    end else begin
      valid_o <= done;
      ferr_o <= done && !rxs;
      if (done) data_o <= frame;
`ifdef UART_RX_PARITY_EN
      perr_o <= done && (^frame ^ par);
`endif
    end
endmodule
